// File: rtl/id_decode_queue.sv
// id_decode_queue: registered MIPS instruction-decode stage with a DEPTH-entry queue.
// Each fetched word is split into fields and its immediate, jump target and class
// are worked out at enqueue time. The head entry drives the outputs.
// Optional feature: define DECODE_ILLEGAL_EN to store and report a per-entry
// undefined-instruction flag on o_out_illegal (tied to 0 otherwise).
module id_decode_queue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [31:0]     i_in_ins,
   input  logic [XLEN-1:0] i_in_pc,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [XLEN-1:0] o_out_pc,
   output logic [5:0]      o_out_op,
   output logic [5:0]      o_out_func,
   output logic [4:0]      o_out_sa,
   output logic [4:0]      o_out_rs,
   output logic [4:0]      o_out_rt,
   output logic [4:0]      o_out_rd,
   output logic [XLEN-1:0] o_out_imm,
   output logic [XLEN-1:0] o_out_jtarget,
   output logic [5:0]      o_out_cls,
   output logic            o_out_illegal
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]     r_ins [DEPTH];
   logic [XLEN-1:0] r_pc  [DEPTH];
   logic [XLEN-1:0] r_imm [DEPTH];
   logic [XLEN-1:0] r_jt  [DEPTH];
   logic [5:0]      r_cls [DEPTH];

   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;

   logic            w_push, w_pop, w_nonempty;
   logic [5:0]      w_op, w_func;
   logic [XLEN-1:0] w_imm, w_jt;
   logic [XLEN-29:0] w_pc4_hi;
   logic [5:0]      w_cls;
   logic [31:0]     w_head_ins;

   assign w_nonempty  = (r_count != '0);
   assign o_in_ready  = (r_count < DEPTH_C);
   assign o_out_valid = w_nonempty;
   // A flush cancels any handshake in the same cycle
   assign w_push      = i_in_valid & o_in_ready & ~i_flush;
   assign w_pop       = w_nonempty & i_out_ready & ~i_flush;

   assign w_op   = i_in_ins[31:26];
   assign w_func = i_in_ins[5:0];
   // Upper bits of pc+4: bits [1:0] cannot carry, so only [27:2] matter for the carry
   assign w_pc4_hi = i_in_pc[XLEN-1:28] + (XLEN-28)'(&i_in_pc[27:2]);
   assign w_jt     = {w_pc4_hi, i_in_ins[25:0], 2'b00};

   // Immediate extension and instruction classification of the incoming word
   always_comb begin
      w_imm = XLEN'($signed(i_in_ins[15:0]));
      w_cls = 6'b000000;
      case (w_op)
         6'h0C, 6'h0D, 6'h0E: w_imm = XLEN'(i_in_ins[15:0]);
         6'h0F:               w_imm = XLEN'({i_in_ins[15:0], 16'h0000});
         default:             ;
      endcase
      case (w_op)
         6'h00:                      w_cls = (w_func == 6'h08) ? 6'b100000 : 6'b000001;
         6'h02, 6'h03:               w_cls = 6'b000010;
         6'h01, 6'h04, 6'h05,
         6'h06, 6'h07:               w_cls = 6'b000100;
         6'h20, 6'h21, 6'h22,
         6'h23, 6'h24, 6'h25:        w_cls = 6'b001000;
         6'h28, 6'h29, 6'h2B:        w_cls = 6'b010000;
         default:                    w_cls = 6'b000000;
      endcase
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      end
   end

   // Entry storage; contents are don't-care until counted, so no reset needed
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_ins[r_wptr] <= i_in_ins;
         r_pc[r_wptr]  <= i_in_pc;
         r_imm[r_wptr] <= w_imm;
         r_jt[r_wptr]  <= w_jt;
         r_cls[r_wptr] <= w_cls;
      end
   end

   assign w_head_ins = r_ins[r_rptr];

   // Head entry to outputs, forced to zero while empty
   always_comb begin
      o_out_pc      = '0;
      o_out_op      = '0;
      o_out_func    = '0;
      o_out_sa      = '0;
      o_out_rs      = '0;
      o_out_rt      = '0;
      o_out_rd      = '0;
      o_out_imm     = '0;
      o_out_jtarget = '0;
      o_out_cls     = '0;
      if (w_nonempty) begin
         o_out_pc      = r_pc[r_rptr];
         o_out_op      = w_head_ins[31:26];
         o_out_func    = w_head_ins[5:0];
         o_out_sa      = w_head_ins[10:6];
         o_out_rs      = w_head_ins[25:21];
         o_out_rt      = w_head_ins[20:16];
         o_out_rd      = w_head_ins[15:11];
         o_out_imm     = r_imm[r_rptr];
         o_out_jtarget = r_jt[r_rptr];
         o_out_cls     = r_cls[r_rptr];
      end
   end

`ifdef DECODE_ILLEGAL_EN
   logic r_ill [DEPTH];
   logic w_ill;

   // Undefined opcode, or undefined function code within the SPECIAL opcode
   always_comb begin
      w_ill = 1'b1;
      case (w_op)
         6'h00: begin
            case (w_func)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B: w_ill = 1'b0;
               default:      w_ill = 1'b1;
            endcase
         end
         6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
         6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h28, 6'h29, 6'h2B: w_ill = 1'b0;
         default:             w_ill = 1'b1;
      endcase
   end

   // Per-entry illegal flag storage
   always_ff @(posedge i_clk) begin
      if (w_push) r_ill[r_wptr] <= w_ill;
   end

   assign o_out_illegal = w_nonempty & r_ill[r_rptr];
`else
   assign o_out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue: directed plus randomized bench for id_decode_queue, checked
// against a queue-based reference model that decodes from the instruction rules.
module tb_id_decode_queue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]     in_ins;
   logic [XLEN-1:0] in_pc, out_pc, out_imm, out_jtarget;
   logic [5:0]      out_op, out_func, out_cls;
   logic [4:0]      out_sa, out_rs, out_rt, out_rd;
   logic            out_illegal;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
   } entry_t;
   entry_t model_q[$];

   id_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_flush       (flush),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_ins      (in_ins),
      .i_in_pc       (in_pc),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_pc      (out_pc),
      .o_out_op      (out_op),
      .o_out_func    (out_func),
      .o_out_sa      (out_sa),
      .o_out_rs      (out_rs),
      .o_out_rt      (out_rt),
      .o_out_rd      (out_rd),
      .o_out_imm     (out_imm),
      .o_out_jtarget (out_jtarget),
      .o_out_cls     (out_cls),
      .o_out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode, written from the instruction-set rules
   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      int unsigned op = ins >> 26;
      int unsigned lo = ins & 32'hFFFF;
      if (op == 12 || op == 13 || op == 14) return lo;
      if (op == 15) return lo * 65536;
      if (lo >= 32768) return lo + 32'hFFFF_0000;
      return lo;
   endfunction

   function automatic logic [31:0] ref_jt(input logic [31:0] ins, input logic [31:0] pc);
      logic [31:0] pc4 = pc + 32'd4;
      return (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
   endfunction

   function automatic logic [5:0] ref_cls(input logic [31:0] ins);
      int unsigned op = ins >> 26;
      int unsigned fn = ins & 63;
      if (op == 0) return (fn == 8) ? 6'b100000 : 6'b000001;
      if (op == 2 || op == 3) return 6'b000010;
      if (op == 1 || (op >= 4 && op <= 7)) return 6'b000100;
      if (op >= 32 && op <= 37) return 6'b001000;
      if (op == 40 || op == 41 || op == 43) return 6'b010000;
      return 6'b000000;
   endfunction

   function automatic logic ref_ill(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_EN
      int unsigned op = ins >> 26;
      int unsigned fn = ins & 63;
      if (op == 0) return !(fn inside {0, 2, 3, 4, 6, 7, 8, 9, [32:39], 42, 43});
      return !(op inside {[0:15], [32:37], 40, 41, 43});
`else
      return (ins == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   // Compare every output against the head of the model queue
   task automatic check_outputs();
      check("in_ready", in_ready, model_q.size() < DEPTH);
      check("out_valid", out_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
         entry_t e = model_q[0];
         check("pc", out_pc, e.pc);
         check("op", out_op, e.ins >> 26);
         check("func", out_func, e.ins & 63);
         check("sa", out_sa, (e.ins >> 6) & 31);
         check("rs", out_rs, (e.ins >> 21) & 31);
         check("rt", out_rt, (e.ins >> 16) & 31);
         check("rd", out_rd, (e.ins >> 11) & 31);
         check("imm", out_imm, ref_imm(e.ins));
         check("jtarget", out_jtarget, ref_jt(e.ins, e.pc));
         check("cls", out_cls, ref_cls(e.ins));
         check("illegal", out_illegal, ref_ill(e.ins));
      end else begin
         check("empty_data", {out_pc, out_op, out_func, out_sa, out_rs, out_rt, out_rd}, 0);
         check("empty_imm_jt", {out_imm, out_jtarget}, 0);
         check("empty_cls", {out_cls, out_illegal}, 0);
      end
   endtask

   // One clock: drive at negedge, advance model at posedge, check at next negedge
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      bit acc, pp;
      in_valid  = v;
      in_ins    = ins;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      acc = v && (model_q.size() < DEPTH);
      pp  = (model_q.size() != 0) && rdy;
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         if (pp) void'(model_q.pop_front());
         if (acc) model_q.push_back('{ins: ins, pc: pc});
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ins = '0; in_pc = '0;
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs();

      // Directed decode examples, streaming with out_ready high
      cycle(1, 32'h2528FFFC, 32'h0040_0000, 1, 0);
      check("t_addiu_op", out_op, 6'h09);
      check("t_addiu_rs", out_rs, 5'd9);
      check("t_addiu_rt", out_rt, 5'd8);
      check("t_addiu_imm", out_imm, 32'hFFFF_FFFC);
      check("t_addiu_cls", out_cls, 6'b000000);
      cycle(1, 32'h34028000, 32'h0040_0004, 1, 0);
      check("t_ori_imm", out_imm, 32'h0000_8000);
      cycle(1, 32'h3C011234, 32'h0040_0008, 1, 0);
      check("t_lui_imm", out_imm, 32'h1234_0000);
      cycle(1, 32'h08000040, 32'h0040_0000, 1, 0);
      check("t_j_target", out_jtarget, 32'h0000_0100);
      check("t_j_cls", out_cls, 6'b000010);
      cycle(1, 32'h03E00008, 32'h0040_0010, 1, 0);
      check("t_jr_cls", out_cls, 6'b100000);
      // jump target takes the upper bits of the wrapped pc+4
      cycle(1, 32'h0FFFFFFF, 32'hFFFF_FFFC, 1, 0);
      check("t_jal_wrap", out_jtarget, 32'h0FFF_FFFC);
      cycle(0, 0, 0, 1, 0);
      check("t_drained", out_valid, 1'b0);

      // Back-pressure: only DEPTH entries accepted, then drain in order
      for (int i = 0; i < DEPTH + 3; i++)
         cycle(1, 32'h8C00_0000 + i, 32'h1000_0000 + 4 * i, 0, 0);
      check("t_full_ready", in_ready, 1'b0);
      check("t_full_head", out_pc, 32'h1000_0000);
      for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, 0);
      check("t_drain_empty", out_valid, 1'b0);

      // Flush while full with a push offered in the flush cycle
      for (int i = 0; i < DEPTH; i++) cycle(1, 32'hAC00_0000 + i, 32'h2000_0000 + 4 * i, 0, 0);
      cycle(1, 32'hDEAD_BEEF, 32'h3000_0000, 1, 1);
      check("t_flush_valid", out_valid, 1'b0);
      check("t_flush_ready", in_ready, 1'b1);
      cycle(0, 0, 0, 1, 0);
      check("t_flush_gone", out_valid, 1'b0);

`ifdef DECODE_ILLEGAL_EN
      cycle(1, 32'hFC00_0000, 32'h0, 1, 0);
      check("t_ill_set", out_illegal, 1'b1);
      cycle(1, 32'h0000_0020, 32'h4, 1, 0);
      check("t_ill_clr", out_illegal, 1'b0);
      cycle(0, 0, 0, 1, 0);
`endif

      // Asynchronous reset in the middle of a cycle with entries queued
      for (int i = 0; i < 3; i++) cycle(1, 32'h2000_0000 + i, 32'h500 + 4 * i, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t_rst_valid", out_valid, 1'b0);
      check("t_rst_ready", in_ready, 1'b1);
      model_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] ins;
         ins = $urandom();
         if ($urandom_range(0, 3) == 0) ins[31:26] = 6'h00;
         cycle($urandom_range(0, 9) < 7, ins, $urandom(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
- Registered, parametrised instruction-decode stage for the MIPS core.
- Accepts fetched instruction words with their PCs over a valid/ready handshake.
- Splits each word into fields and performs immediate extension, jump-target formation and instruction classification at enqueue time.
- Buffers up to DEPTH decoded entries so fetch can run ahead of a stalled execute stage. Sits between fetch and register-read/execute.

Parameters:
- XLEN, 32, width of the extended immediate, PC and jump-target outputs (≥32).
- DEPTH, 2, number of decoded entries held; power of two, ≥2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all queued entries
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept this cycle
- in_ins  input  32  instruction word
- in_pc  input  XLEN  address of in_ins
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- out_pc  output  XLEN  PC of head entry
- out_op  output  6  ins[31:26]
- out_func  output  6  ins[5:0]
- out_sa  output  5  ins[10:6]
- out_rs  output  5  ins[25:21]
- out_rt  output  5  ins[20:16]
- out_rd  output  5  ins[15:11]
- out_imm  output  XLEN  extended ins[15:0]
- out_jtarget  output  XLEN  jump target
- out_cls  output  6  one-hot class {jr, store, load, branch, jump, rtype}
- out_illegal  output  1  undefined opcode (feature-gated)

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read/write pointers=0, out_valid=0, in_ready=1. All data outputs read 0 while empty.
- Push: when in_valid && in_ready at a rising edge, the decoded entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: when out_valid && out_ready at a rising edge, the read pointer increments modulo DEPTH.
- count changes by +1 on push only, −1 on pop only, and is unchanged when both occur in the same cycle.
- in_ready = (count < DEPTH). It is purely registered state, with no combinational path from out_ready.
  - When full, no push occurs even if a pop happens the same cycle; the slot is reused next cycle.
- out_valid = (count != 0). Data outputs come from the head storage entry, with no combinational path from in_* to out_*.
- Latency: an entry pushed at edge N is visible at out_* after edge N if the queue was empty. Empty-queue throughput is 1 per cycle.
- Decode rules:
  - out_imm is zero-extended for op 0x0C, 0x0D, 0x0E (andi/ori/xori). For op 0x0F (lui), out_imm = {ins[15:0], 16'h0} zero-extended. All other ops sign-extend.
  - out_jtarget = {pc_plus4[XLEN-1:28], ins[25:0], 2'b00}, where pc_plus4 = in_pc + 4 wrapping modulo 2^XLEN.
  - Classes:
    - rtype: op=0x00, func≠0x08.
    - jr: op=0x00, func=0x08.
    - jump: op=0x02/0x03.
    - branch: op=0x01, 0x04–0x07.
    - load: op=0x20–0x25.
    - store: op=0x28, 0x29, 0x2B.
    - Other ops give out_cls=0.
- Flush (synchronous): at the edge where flush=1, count and both pointers clear to 0. Any push or pop in that cycle is discarded. out_valid=0 and in_ready=1 the next cycle.
- Reset asserted mid-transfer discards all entries immediately; no partial state survives.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: out_illegal=1 for ops outside the set {0x00–0x0F, 0x20–0x25, 0x28, 0x29, 0x2B}, and for op=0x00 with func outside {0x00, 0x02, 0x03, 0x04, 0x06, 0x07, 0x08, 0x09, 0x20–0x27, 0x2A, 0x2B}. The flag is stored per entry.
- Undefined: out_illegal is tied to 0 and no storage bit is implemented.

Test Plan:
- Reset, then push in_ins=0x2528FFFC, in_pc=0x00400000 → next cycle out_valid=1, out_op=0x09, out_rs=9, out_rt=8, out_imm=0xFFFFFFFC, out_cls=0.
- Push 0x34028000 (ori) and then 0x3C011234 (lui) → out_imm=0x00008000, then 0x12340000.
- Push 0x08000040 at pc 0x00400000 → out_jtarget=0x00000100, out_cls=jump. Push 0x03E00008 → out_cls=jr.
- out_ready=0 with continuous pushes → exactly DEPTH accepted, in_ready=0; then out_ready=1 → entries drain in push order with no loss or duplication.
- Queue full with flush=1 and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- With DECODE_ILLEGAL_EN defined, push 0xFC000000 → out_illegal=1; push 0x00000020 → out_illegal=0.
